// File: rtl/branch_predictor_bht_if.sv
// Decode-side prediction and EX-side resolution signals of the bimodal branch predictor.
// The pipeline drives through master; the predictor sits on slave.
interface branch_predictor_bht_if;
  logic [31:0] i_dec_pc;
  logic        i_dec_valid;
  logic        i_dec_is_jump;
  logic [31:0] i_dec_target;
  logic        o_prediction;
  logic [31:0] o_target_post_predict;
  logic        i_ex_valid;
  logic [31:0] i_ex_pc;
  logic        i_ex_prediction;
  logic        i_ex_outcome;
  logic [31:0] o_branch_count;
  logic [31:0] o_mispredict_count;

  modport master (
    output i_dec_pc, i_dec_valid, i_dec_is_jump, i_dec_target,
    output i_ex_valid, i_ex_pc, i_ex_prediction, i_ex_outcome,
    input  o_prediction, o_target_post_predict,
    input  o_branch_count, o_mispredict_count
  );

  modport slave (
    input  i_dec_pc, i_dec_valid, i_dec_is_jump, i_dec_target,
    input  i_ex_valid, i_ex_pc, i_ex_prediction, i_ex_outcome,
    output o_prediction, o_target_post_predict,
    output o_branch_count, o_mispredict_count
  );
endinterface

// File: rtl/branch_predictor_bht.sv
// Bimodal predictor: untagged table of 2-bit saturating counters indexed by PC[INDEX_BITS+1:2],
// combinational lookup in decode, registered training from EX, plus branch/mispredict counters.
module branch_predictor_bht #(
  parameter int unsigned INDEX_BITS = 6,
  parameter logic [1:0]  CTR_RESET  = 2'b01
) (
  input logic             clk,
  input logic             rst_n,
  branch_predictor_bht_if.slave bp
);

  localparam int unsigned DEPTH = 1 << INDEX_BITS;

  logic [1:0]            bht_q [DEPTH];
  logic [31:0]           branch_count_q;
  logic [31:0]           mispredict_count_q;

  logic [INDEX_BITS-1:0] idx_d;
  logic [INDEX_BITS-1:0] idx_e;
  logic [1:0]            ctr_cur;
  logic [1:0]            ctr_next;
  logic                  prediction;
  logic [31:0]           fallthrough;

  assign idx_d       = bp.i_dec_pc[INDEX_BITS+1:2];
  assign idx_e       = bp.i_ex_pc[INDEX_BITS+1:2];
  assign fallthrough = bp.i_dec_pc + 32'd4;

  // Lookup reads the registered table only, so a same-cycle update to this entry is not seen.
  always_comb begin
    prediction                = 1'b0;
    bp.o_target_post_predict  = fallthrough;
    if (bp.i_dec_valid) begin
      prediction = bp.i_dec_is_jump ? 1'b1 : bht_q[idx_d][1];
      if (prediction) begin
        bp.o_target_post_predict = bp.i_dec_target;
      end
    end
  end

  assign bp.o_prediction = prediction;

  always_comb begin
    ctr_cur  = bht_q[idx_e];
    ctr_next = ctr_cur;
    if (bp.i_ex_outcome) begin
      if (ctr_cur != 2'b11) ctr_next = ctr_cur + 2'd1;
    end else begin
      if (ctr_cur != 2'b00) ctr_next = ctr_cur - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        bht_q[i] <= CTR_RESET;
      end
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else if (bp.i_ex_valid) begin
      bht_q[idx_e]   <= ctr_next;
      branch_count_q <= branch_count_q + 32'd1;
      if (bp.i_ex_prediction != bp.i_ex_outcome) begin
        mispredict_count_q <= mispredict_count_q + 32'd1;
      end
    end
  end

  assign bp.o_branch_count     = branch_count_q;
  assign bp.o_mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed bench for branch_predictor_bht: expectations are queued as stimulus is applied
// and popped against the DUT outputs.
module tb_branch_predictor_bht;

  logic clk;
  logic rst_n;

  branch_predictor_bht_if bp ();

  branch_predictor_bht #(
    .INDEX_BITS (6),
    .CTR_RESET  (2'b01)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic push_exp(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_dec(input string tag, input logic pred, input logic [31:0] tgt);
    push_exp({tag, "_pred"}, {31'd0, pred});
    push_exp({tag, "_tgt"}, tgt);
    #1;
    check({31'd0, bp.o_prediction});
    check(bp.o_target_post_predict);
  endtask

  task automatic expect_cnt(input string tag, input logic [31:0] br, input logic [31:0] mp);
    push_exp({tag, "_branches"}, br);
    push_exp({tag, "_mispredicts"}, mp);
    check(bp.o_branch_count);
    check(bp.o_mispredict_count);
  endtask

  task automatic set_dec(input logic v, input logic j, input logic [31:0] pc, input logic [31:0] tgt);
    bp.i_dec_valid   = v;
    bp.i_dec_is_jump = j;
    bp.i_dec_pc      = pc;
    bp.i_dec_target  = tgt;
  endtask

  task automatic ex_update(input logic [31:0] pc, input logic pred, input logic outcome);
    bp.i_ex_valid      = 1'b1;
    bp.i_ex_pc         = pc;
    bp.i_ex_prediction = pred;
    bp.i_ex_outcome    = outcome;
    step();
    bp.i_ex_valid      = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bp.i_ex_valid      = 1'b0;
    bp.i_ex_pc         = '0;
    bp.i_ex_prediction = 1'b0;
    bp.i_ex_outcome    = 1'b0;
    set_dec(1'b1, 1'b0, 32'h100, 32'h200);

    // reset state
    step();
    expect_dec("t1_reset", 1'b0, 32'h104);
    expect_cnt("t1_reset", 0, 0);
    rst_n = 1'b1;

    // no branch in decode: fall-through, even if is_jump is high
    set_dec(1'b0, 1'b1, 32'h1230, 32'h9);
    expect_dec("idle", 1'b0, 32'h1234);

    // single taken update flips weakly-not-taken to weakly-taken
    ex_update(32'h100, 1'b0, 1'b1);
    set_dec(1'b1, 1'b0, 32'h100, 32'h200);
    expect_dec("t2_trained", 1'b1, 32'h200);
    expect_cnt("t2", 1, 1);

    // saturate high, then back off
    set_dec(1'b1, 1'b0, 32'h40, 32'h80);
    for (int i = 0; i < 4; i++) ex_update(32'h40, 1'b1, 1'b1);
    expect_cnt("t3_sat_hi", 5, 1);
    ex_update(32'h40, 1'b1, 1'b0);
    expect_dec("t3_one_nt", 1'b1, 32'h80);
    ex_update(32'h40, 1'b1, 1'b0);
    expect_dec("t3_two_nt", 1'b0, 32'h44);
    expect_cnt("t3", 7, 3);

    // saturate low: 01 -> 00 -> 00, one taken gives 01 (still not-taken), second gives 10
    ex_update(32'h40, 1'b0, 1'b0);
    ex_update(32'h40, 1'b0, 1'b0);
    ex_update(32'h40, 1'b0, 1'b1);
    expect_dec("t3_sat_lo", 1'b0, 32'h44);
    ex_update(32'h40, 1'b0, 1'b1);
    expect_dec("t3_recover", 1'b1, 32'h80);
    expect_cnt("t3_lo", 11, 5);

    // same-cycle update and lookup of one entry: no bypass
    set_dec(1'b1, 1'b0, 32'h80, 32'h300);
    bp.i_ex_valid      = 1'b1;
    bp.i_ex_pc         = 32'h80;
    bp.i_ex_prediction = 1'b0;
    bp.i_ex_outcome    = 1'b1;
    expect_dec("t4_same_cycle", 1'b0, 32'h84);
    step();
    bp.i_ex_valid = 1'b0;
    expect_dec("t4_next_cycle", 1'b1, 32'h300);
    expect_cnt("t4", 12, 6);

    // jumps ignore the table
    set_dec(1'b1, 1'b1, 32'h80, 32'h4000);
    expect_dec("t5_jump_taken_entry", 1'b1, 32'h4000);
    set_dec(1'b1, 1'b1, 32'h8, 32'h4000);
    expect_dec("t5_jump_fresh_entry", 1'b1, 32'h4000);

    // aliasing: 0x4 and 0x104 share index 1
    ex_update(32'h4, 1'b1, 1'b1);
    ex_update(32'h4, 1'b1, 1'b1);
    set_dec(1'b1, 1'b0, 32'h104, 32'h500);
    expect_dec("t5_alias", 1'b1, 32'h500);
    expect_cnt("t5", 14, 6);

    // reset wins over a same-cycle update
    rst_n = 1'b0;
    ex_update(32'h100, 1'b0, 1'b1);
    rst_n = 1'b1;
    expect_cnt("t6_reset", 0, 0);
    set_dec(1'b1, 1'b0, 32'h100, 32'h200);
    expect_dec("t6_entry0", 1'b0, 32'h104);
    set_dec(1'b1, 1'b0, 32'h104, 32'h500);
    expect_dec("t6_entry1", 1'b0, 32'h108);

    // counting resumes from zero; a correct not-taken prediction is not a mispredict
    ex_update(32'h100, 1'b0, 1'b0);
    expect_cnt("t6_after", 1, 0);
    set_dec(1'b1, 1'b0, 32'h100, 32'h200);
    expect_dec("t6_after_nt", 1'b0, 32'h104);

    if (sb.size() != 0) begin
      miscompares++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
